shift_reg_piso_tx: RTL and testbench
====================================

// Module: shift_reg_piso_tx
// PURPOSE
//  Parallel-in/serial-out transmitter: accepts a WIDTH-bit word over a valid/ready
//  handshake and shifts it out one bit per clk on sdo, with framing strobes.
//  Drives the serial input (sdi) of the downstream shift-register/deserializer chain.
//  Back-to-back words stream with no idle bit when GAP_CYCLES = 0.
// PARAMETERS
//  WIDTH       8   word width in bits (>= 2)
//  MSB_FIRST   1   1: bit WIDTH-1 sent first; 0: bit 0 sent first
//  GAP_CYCLES  0   idle cycles inserted after each word (0..255)
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      synchronous, active-high reset
//  din        in   WIDTH  parallel word to send
//  din_valid  in   1      din holds a word to send
//  din_ready  out  1      transmitter can accept din this cycle
//  sdo        out  1      serial data out
//  sdo_valid  out  1      sdo carries a data bit this cycle
//  sof        out  1      high during first bit of a word
//  eof        out  1      high during last bit of a word
//  busy       out  1      high in SHIFT or GAP
// BEHAVIOUR
//  - Reset (reset=1 at a rising edge): state=IDLE; sdo=0, sdo_valid=0, sof=0, eof=0,
//    busy=0; bit counter=0; shift register cleared. Reset wins over every other input;
//    a word in flight is dropped, with no further bits.
//  - Handshake: transfer occurs at a rising edge where din_valid && din_ready. din is
//    sampled only at that edge; din/din_valid are ignored while din_ready=0.
//  - din_ready is combinational from state and counter: 1 in IDLE; 1 in SHIFT on the
//    last bit only if GAP_CYCLES==0; 0 otherwise.
//  - FSM states IDLE, SHIFT, GAP:
//    IDLE  -> SHIFT on transfer (load shift reg, cnt=0).
//    SHIFT -> each edge: shift by 1, cnt+1. On the last bit edge (cnt==WIDTH-1):
//             a transfer reloads and stays SHIFT (cnt=0); else GAP_CYCLES>0 -> GAP
//             (gap cnt=0); else IDLE.
//    GAP   -> counts GAP_CYCLES cycles, then IDLE. No transfer accepted in GAP.
//  - Latency: the first bit appears on sdo in the cycle directly after the transfer edge.
//    Each bit holds exactly one cycle; a word occupies WIDTH consecutive cycles.
//  - In SHIFT: sdo_valid=1, sdo = current bit (registered output, no glitch);
//    sof=1 when cnt==0, eof=1 when cnt==WIDTH-1. In IDLE/GAP: sdo=0, sdo_valid=sof=eof=0.
//  - Bit order per MSB_FIRST; bit order is the same for every word.
//  - Counters sized $clog2(WIDTH) and 8 bits; cnt never exceeds WIDTH-1.
// TESTING
//  1 Reset: hold reset 2 cycles with din_valid=1 -> all outputs 0, din_ready=1, no transfer.
//  2 Single word, WIDTH=8, MSB_FIRST=1, din=8'hA5 one-cycle valid -> sdo=1,0,1,0,0,1,0,1
//    on 8 consecutive cycles starting the cycle after the transfer; sof on bit 1,
//    eof on bit 8; then sdo_valid=0, din_ready=1.
//  3 Back-to-back, GAP=0: 8'hF0 then 8'h0F with valid held -> 16 contiguous valid bits
//    11110000_00001111; din_ready pulses on the last bit; sof/eof alternate with no gap.
//  4 MSB_FIRST=0, GAP=2: 8'h01 then 8'h80 -> 1,0x7, then 2 idle cycles (din_ready=0,
//    busy=1), then 0x7,1.
//  5 Reset mid-word: assert reset after bit 3 of 8'hFF -> sdo_valid=0 next cycle,
//    remaining bits never sent; a new word after reset is transmitted intact.
//  6 Ignored input: toggle din while din_ready=0 -> serial stream equals originally
//    accepted word.

Source files
------------

// File: rtl/shift_reg_piso_tx.sv
// -----------------------------------------------------------------------------
// shift_reg_piso_tx
//   Parallel-in / serial-out transmitter. Accepts a WIDTH-bit word over a
//   valid/ready handshake and shifts it out one bit per clock on sdo, with
//   first/last-bit framing strobes. With GAP_CYCLES = 0, consecutive words
//   stream with no idle bit between them.
//
// Parameters
//   WIDTH       word width in bits (>= 2)
//   MSB_FIRST   1: bit WIDTH-1 leaves first, 0: bit 0 leaves first
//   GAP_CYCLES  idle cycles inserted after every word (0..255)
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high reset
//   din        in   parallel word to send
//   din_valid  in   din holds a word to send
//   din_ready  out  word can be accepted this cycle (combinational)
//   sdo        out  serial data bit (registered)
//   sdo_valid  out  sdo carries a data bit this cycle
//   sof        out  first bit of a word
//   eof        out  last bit of a word
//   busy       out  shifting or in the inter-word gap
// -----------------------------------------------------------------------------
module shift_reg_piso_tx #(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter int GAP_CYCLES = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sdo,
    output logic             sdo_valid,
    output logic             sof,
    output logic             eof,
    output logic             busy
);

    localparam int                CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);
    // Unreachable when GAP_CYCLES == 0; the truncation is harmless then.
    localparam logic [7:0]        GAP_LAST = 8'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       gap_q, gap_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             vld_q, vld_d;
    logic             sof_q, sof_d;
    logic             eof_q, eof_d;

    logic             last_bit;
    logic             xfer;

    // Advance the word by one bit so the next bit sits at the output end.
    function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] v);
        if (MSB_FIRST) begin
            return {v[WIDTH-2:0], 1'b0};
        end else begin
            return {1'b0, v[WIDTH-1:1]};
        end
    endfunction

    assign last_bit  = (state_q == SHIFT) && (cnt_q == CNT_LAST);
    assign din_ready = (state_q == IDLE) || (last_bit && (GAP_CYCLES == 0));
    assign xfer      = din_valid && din_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        shreg_d = shreg_q;

        case (state_q)
            IDLE: begin
                if (xfer) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    shreg_d = din;
                end
            end
            SHIFT: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (xfer) begin
                        shreg_d = din;
                    end else begin
                        // Clearing the shift register makes sdo read 0 while idle.
                        shreg_d = '0;
                        if (GAP_CYCLES > 0) begin
                            state_d = GAP;
                            gap_d   = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    shreg_d = shift_one(shreg_q);
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = IDLE;
                    gap_d   = '0;
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                gap_d   = '0;
                shreg_d = '0;
            end
        endcase

        // Strobes are decoded from the next state so they leave a flop.
        vld_d = (state_d == SHIFT);
        sof_d = vld_d && (cnt_d == '0);
        eof_d = vld_d && (cnt_d == CNT_LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            gap_q   <= '0;
            shreg_q <= '0;
            vld_q   <= 1'b0;
            sof_q   <= 1'b0;
            eof_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            shreg_q <= shreg_d;
            vld_q   <= vld_d;
            sof_q   <= sof_d;
            eof_q   <= eof_d;
        end
    end

    assign sdo       = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
    assign sdo_valid = vld_q;
    assign sof       = sof_q;
    assign eof       = eof_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_shift_reg_piso_tx.sv
module tb_shift_reg_piso_tx;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: WIDTH=8, MSB_FIRST=1, GAP_CYCLES=0
    logic       rst_a, vin_a, rdy_a, sdo_a, vld_a, sof_a, eof_a, busy_a;
    logic [7:0] din_a;
    // DUT B: WIDTH=8, MSB_FIRST=0, GAP_CYCLES=2
    logic       rst_b, vin_b, rdy_b, sdo_b, vld_b, sof_b, eof_b, busy_b;
    logic [7:0] din_b;

    int checks = 0;
    int passes = 0;

    shift_reg_piso_tx #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP_CYCLES(0)) u_a (
        .clk(clk), .reset(rst_a), .din(din_a), .din_valid(vin_a), .din_ready(rdy_a),
        .sdo(sdo_a), .sdo_valid(vld_a), .sof(sof_a), .eof(eof_a), .busy(busy_a)
    );

    shift_reg_piso_tx #(.WIDTH(8), .MSB_FIRST(1'b0), .GAP_CYCLES(2)) u_b (
        .clk(clk), .reset(rst_b), .din(din_b), .din_valid(vin_b), .din_ready(rdy_b),
        .sdo(sdo_b), .sdo_valid(vld_b), .sof(sof_b), .eof(eof_b), .busy(busy_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %b expected %b", tag, obs, exp);
    endtask

    task automatic chk_a(input string tag, input int i, input logic e_sdo, input logic e_vld,
                         input logic e_sof, input logic e_eof, input logic e_rdy, input logic e_busy);
        chk($sformatf("%s[%0d].sdo", tag, i), sdo_a, e_sdo);
        chk($sformatf("%s[%0d].sdo_valid", tag, i), vld_a, e_vld);
        chk($sformatf("%s[%0d].sof", tag, i), sof_a, e_sof);
        chk($sformatf("%s[%0d].eof", tag, i), eof_a, e_eof);
        chk($sformatf("%s[%0d].din_ready", tag, i), rdy_a, e_rdy);
        chk($sformatf("%s[%0d].busy", tag, i), busy_a, e_busy);
    endtask

    task automatic chk_b(input string tag, input int i, input logic e_sdo, input logic e_vld,
                         input logic e_sof, input logic e_eof, input logic e_rdy, input logic e_busy);
        chk($sformatf("%s[%0d].sdo", tag, i), sdo_b, e_sdo);
        chk($sformatf("%s[%0d].sdo_valid", tag, i), vld_b, e_vld);
        chk($sformatf("%s[%0d].sof", tag, i), sof_b, e_sof);
        chk($sformatf("%s[%0d].eof", tag, i), eof_b, e_eof);
        chk($sformatf("%s[%0d].din_ready", tag, i), rdy_b, e_rdy);
        chk($sformatf("%s[%0d].busy", tag, i), busy_b, e_busy);
    endtask

    logic [7:0]  exp8;
    logic [15:0] exp16;

    initial begin
        rst_a = 1'b1; vin_a = 1'b1; din_a = 8'h3C;
        rst_b = 1'b1; vin_b = 1'b1; din_b = 8'hC3;

        // Test 1: reset held two cycles with din_valid high
        tick();
        chk_a("rst1", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_b("rst1", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        chk_a("rst2", 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_b("rst2", 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        rst_a = 1'b0; vin_a = 1'b0;
        rst_b = 1'b0; vin_b = 1'b0;
        tick();
        chk_a("post_rst", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Test 2: single word A5, MSB first
        exp8 = 8'b1010_0101;
        din_a = 8'hA5; vin_a = 1'b1;
        tick();
        vin_a = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk_a("a5", i, exp8[7-i], 1'b1, i == 0, i == 7, i == 7, 1'b1);
            tick();
        end
        chk_a("a5_end", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Test 3: back-to-back F0 then 0F, valid held
        exp16 = 16'b1111_0000_0000_1111;
        din_a = 8'hF0; vin_a = 1'b1;
        tick();
        din_a = 8'h0F;
        for (int i = 0; i < 16; i++) begin
            chk_a("b2b", i, exp16[15-i], 1'b1, (i % 8) == 0, (i % 8) == 7, (i % 8) == 7, 1'b1);
            tick();
            if (i == 7) vin_a = 1'b0;
        end
        chk_a("b2b_end", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Test 6: din/din_valid toggled while din_ready=0 are ignored
        exp8 = 8'b0011_1100;
        din_a = 8'h3C; vin_a = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            chk_a("ign", i, exp8[7-i], 1'b1, i == 0, i == 7, i == 7, 1'b1);
            if (i < 7) begin
                din_a = ~din_a ^ 8'(i);
                vin_a = (i % 2) == 0;
            end else begin
                vin_a = 1'b0;
            end
            tick();
        end
        chk_a("ign_end", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Test 5: reset after bit 3 of FF, then a fresh word 96
        din_a = 8'hFF; vin_a = 1'b1;
        tick();
        vin_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk_a("midrst", i, 1'b1, 1'b1, i == 0, 1'b0, 1'b0, 1'b1);
            if (i == 2) rst_a = 1'b1;
            tick();
        end
        chk_a("midrst_rst", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        rst_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_a("midrst_quiet", i, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        exp8 = 8'b1001_0110;
        din_a = 8'h96; vin_a = 1'b1;
        tick();
        vin_a = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk_a("after_rst", i, exp8[7-i], 1'b1, i == 0, i == 7, i == 7, 1'b1);
            tick();
        end
        chk_a("after_rst_end", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Test 4: DUT B, LSB first with a 2-cycle gap: 01 then 80
        exp8 = 8'b0000_0001;
        din_b = 8'h01; vin_b = 1'b1;
        tick();
        din_b = 8'h80;
        for (int i = 0; i < 8; i++) begin
            chk_b("lsb01", i, exp8[i], 1'b1, i == 0, i == 7, 1'b0, 1'b1);
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            chk_b("gap", i, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            tick();
        end
        chk_b("idle", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        vin_b = 1'b0;
        exp8 = 8'b1000_0000;
        for (int i = 0; i < 8; i++) begin
            chk_b("lsb80", i, exp8[i], 1'b1, i == 0, i == 7, 1'b0, 1'b1);
            tick();
        end
        chk_b("gap2", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        chk_b("lsb_end", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
